register_project: RTL and testbench

REGISTER_PROJECT -- requirements
Module: register_project

---
 rtl/router_pkg.sv | 47 ++++
 rtl/router_if.sv | 41 ++++
 rtl/router_parity_chk.sv | 86 ++++++++
 rtl/register_project.sv | 107 ++++++++++
 tb/tb_register_project.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router register block.
//   DATA_WIDTH_DEF     default byte width for header, payload and parity
//   ADDR_MSB/ADDR_LSB  bit range of the port address inside the header byte
//   router_state_e     router FSM state encodings
//   state_dec_t        one-hot state decodes that the FSM presents to this block
//   decode_state()     maps an FSM state to its one-hot decodes
package router_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_MSB       = 1;
  localparam int ADDR_LSB       = 0;

  typedef enum logic [2:0] {
    ST_IDLE            = 3'd0,
    ST_DECODE_ADDRESS  = 3'd1,
    ST_LOAD_FIRST_DATA = 3'd2,
    ST_LOAD_DATA       = 3'd3,
    ST_FIFO_FULL       = 3'd4,
    ST_LOAD_AFTER_FULL = 3'd5,
    ST_RST_INT_REG     = 3'd6
  } router_state_e;

  typedef struct packed {
    logic detect_add;
    logic lfd_state;
    logic ld_state;
    logic laf_state;
    logic full_state;
    logic rst_int_reg;
  } state_dec_t;

  function automatic state_dec_t decode_state(router_state_e st);
    state_dec_t d;
    d = '0;
    case (st)
      ST_DECODE_ADDRESS:  d.detect_add  = 1'b1;
      ST_LOAD_FIRST_DATA: d.lfd_state   = 1'b1;
      ST_LOAD_DATA:       d.ld_state    = 1'b1;
      ST_FIFO_FULL:       d.full_state  = 1'b1;
      ST_LOAD_AFTER_FULL: d.laf_state   = 1'b1;
      ST_RST_INT_REG:     d.rst_int_reg = 1'b1;
      default:            d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/router_if.sv
// Byte/handshake bundle between the packet source, the router FSM decodes,
// the output FIFO and the register block.
//   slave  : register block side (inputs: source byte, FIFO full, state
//            decodes; outputs: dout, parity_done, low_pkt_valid, err)
//   master : source/FSM/FIFO side, directions mirrored
// Handshake: a byte on data_in is consumed on a rising edge only while the
// FSM decode says so (detect_add for the header, ld_state/laf_state for
// payload and parity); pkt_valid=0 marks data_in as the parity byte, and
// fifo_full=1 stalls the dout write, the byte then being kept in a hold
// register until laf_state.
interface router_if
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  pkt_valid;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  fifo_full;
  logic                  detect_add;
  logic                  lfd_state;
  logic                  ld_state;
  logic                  laf_state;
  logic                  full_state;
  logic                  rst_int_reg;
  logic [DATA_WIDTH-1:0] dout;
  logic                  parity_done;
  logic                  low_pkt_valid;
  logic                  err;

  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_pkt_valid, err
  );

  modport master (
    output pkt_valid, data_in, fifo_full,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_pkt_valid, err
  );
endinterface

// File: rtl/router_parity_chk.sv
// Parity tracking for one packet: running XOR of header and payload, the
// received parity byte, and the error flag.
//   clk, rst           clock and synchronous active-high reset
//   detect_add..laf    priority-resolved state decodes
//   full_state         FSM is stalled on a full FIFO
//   pkt_valid          low while the parity byte is on data_in
//   fifo_full          output FIFO full
//   low_pkt_valid      parity byte seen while a load was pending
//   parity_done        parity byte has been captured
//   header, data_in    registered header byte and live source byte
//   err                running parity differs from received parity
module router_parity_chk
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  detect_add,
  input  logic                  lfd_state,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  pkt_valid,
  input  logic                  fifo_full,
  input  logic                  low_pkt_valid,
  input  logic                  parity_done,
  input  logic [DATA_WIDTH-1:0] header,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] int_parity_q, int_parity_d;
  logic [DATA_WIDTH-1:0] pkt_parity_q, pkt_parity_d;
  logic                  pd_dly_q, pd_dly_d;
  logic                  err_q, err_d;

  always_comb begin
    int_parity_d = int_parity_q;
    pkt_parity_d = pkt_parity_q;
    pd_dly_d     = parity_done;
    err_d        = err_q;

    if (detect_add) begin
      int_parity_d = '0;
    end else if (lfd_state) begin
      int_parity_d = int_parity_q ^ header;
    end else if (ld_state && pkt_valid && !full_state) begin
      // A payload byte stalled by fifo_full is still folded in here, once;
      // the later laf_state replay of the byte does not touch the parity.
      int_parity_d = int_parity_q ^ data_in;
    end

    if (ld_state && !pkt_valid && !fifo_full) begin
      pkt_parity_d = data_in;
    end else if (laf_state && low_pkt_valid) begin
      // Parity byte arrived while the FIFO was full; the source holds it.
      pkt_parity_d = data_in;
    end

    // Compare one cycle after parity_done rises, when both parity
    // registers hold their final values.
    if (detect_add) begin
      err_d = 1'b0;
    end else if (parity_done && !pd_dly_q) begin
      err_d = (int_parity_q != pkt_parity_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      int_parity_q <= '0;
      pkt_parity_q <= '0;
      pd_dly_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      int_parity_q <= int_parity_d;
      pkt_parity_q <= pkt_parity_d;
      pd_dly_q     <= pd_dly_d;
      err_q        <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/register_project.sv
// Router register block: header/hold/output byte registers plus packet
// status flags; parity tracking lives in router_parity_chk.
//   clockr  sole clock, rising edge
//   resetr  synchronous active-high reset
//   bus     router_if slave: source byte, FIFO full, FSM state decodes in;
//           dout, parity_done, low_pkt_valid, err out
module register_project
  import router_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input logic      clockr,
  input logic      resetr,
  router_if.slave  bus
);

  logic [DATA_WIDTH-1:0] header_q, header_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  parity_done_q, parity_done_d;
  logic                  low_pkt_valid_q, low_pkt_valid_d;

  // Only one decode should be active; if several are, the earlier one in
  // the packet flow wins so the block behaves deterministically.
  logic det, lfd, ld, laf;
  assign det = bus.detect_add;
  assign lfd = bus.lfd_state && !bus.detect_add;
  assign ld  = bus.ld_state  && !bus.detect_add && !bus.lfd_state;
  assign laf = bus.laf_state && !bus.detect_add && !bus.lfd_state && !bus.ld_state;

  always_comb begin
    header_d        = header_q;
    hold_d          = hold_q;
    dout_d          = dout_q;
    parity_done_d   = parity_done_q;
    low_pkt_valid_d = low_pkt_valid_q;

    if (det && bus.pkt_valid) begin
      header_d = bus.data_in;
    end

    if (lfd) begin
      dout_d = header_q;
    end else if (ld && !bus.fifo_full) begin
      dout_d = bus.data_in;
    end else if (laf) begin
      dout_d = hold_q;
    end

    // Keep the byte that could not be written so it survives the stall.
    if (ld && bus.fifo_full) begin
      hold_d = bus.data_in;
    end

    // Set has priority over the clear from rst_int_reg.
    if (ld && !bus.pkt_valid) begin
      low_pkt_valid_d = 1'b1;
    end else if (bus.rst_int_reg) begin
      low_pkt_valid_d = 1'b0;
    end

    if (det) begin
      parity_done_d = 1'b0;
    end else if ((ld && !bus.fifo_full && !bus.pkt_valid) ||
                 (laf && low_pkt_valid_q && !parity_done_q)) begin
      parity_done_d = 1'b1;
    end
  end

  always_ff @(posedge clockr) begin
    if (resetr) begin
      header_q        <= '0;
      hold_q          <= '0;
      dout_q          <= '0;
      parity_done_q   <= 1'b0;
      low_pkt_valid_q <= 1'b0;
    end else begin
      header_q        <= header_d;
      hold_q          <= hold_d;
      dout_q          <= dout_d;
      parity_done_q   <= parity_done_d;
      low_pkt_valid_q <= low_pkt_valid_d;
    end
  end

  router_parity_chk #(.DATA_WIDTH(DATA_WIDTH)) u_parity_chk (
    .clk           (clockr),
    .rst           (resetr),
    .detect_add    (det),
    .lfd_state     (lfd),
    .ld_state      (ld),
    .laf_state     (laf),
    .full_state    (bus.full_state),
    .pkt_valid     (bus.pkt_valid),
    .fifo_full     (bus.fifo_full),
    .low_pkt_valid (low_pkt_valid_q),
    .parity_done   (parity_done_q),
    .header        (header_q),
    .data_in       (bus.data_in),
    .err           (bus.err)
  );

  assign bus.dout          = dout_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;

endmodule

// File: tb/tb_register_project.sv
module tb_register_project;
  import router_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clockr = 1'b0;
  logic resetr = 1'b1;
  always #5 clockr = ~clockr;

  router_if #(.DATA_WIDTH(W)) bus ();

  register_project #(.DATA_WIDTH(W)) dut (
    .clockr (clockr),
    .resetr (resetr),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    bit            rst;
    router_state_e st;
    logic          pv;
    logic          ff;
    logic [W-1:0]  din;
    logic [W-1:0]  e_dout;
    logic          e_pd;
    logic          e_lpv;
    logic          e_err;
  } vec_t;

  vec_t tbl[$];

  // ---------------- driver tasks ----------------
  task automatic drive(input router_state_e st, input logic pv, input logic ff,
                       input logic [W-1:0] din);
    state_dec_t d;
    d = decode_state(st);
    bus.detect_add  = d.detect_add;
    bus.lfd_state   = d.lfd_state;
    bus.ld_state    = d.ld_state;
    bus.laf_state   = d.laf_state;
    bus.full_state  = d.full_state;
    bus.rst_int_reg = d.rst_int_reg;
    bus.pkt_valid   = pv;
    bus.fifo_full   = ff;
    bus.data_in     = din;
  endtask

  // Advance one clock and sample just after the edge.
  task automatic step();
    @(posedge clockr);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [W-1:0] e_dout, input logic e_pd,
                            input logic e_lpv, input logic e_err);
    check({tag, " dout"}, 32'(bus.dout), 32'(e_dout));
    check({tag, " parity_done"}, 32'(bus.parity_done), 32'(e_pd));
    check({tag, " low_pkt_valid"}, 32'(bus.low_pkt_valid), 32'(e_lpv));
    check({tag, " err"}, 32'(bus.err), 32'(e_err));
  endtask

  task automatic add_row(input bit rst, input router_state_e st, input logic pv, input logic ff,
                         input logic [W-1:0] din, input logic [W-1:0] e_dout,
                         input logic e_pd, input logic e_lpv, input logic e_err);
    vec_t v;
    v.rst = rst; v.st = st; v.pv = pv; v.ff = ff; v.din = din;
    v.e_dout = e_dout; v.e_pd = e_pd; v.e_lpv = e_lpv; v.e_err = e_err;
    tbl.push_back(v);
  endtask

  // Random packet through a source/FSM sequencer; expected values come from
  // the packet itself: dout stream = header, payload, parity in order, and
  // err = (XOR of header and payload) != received parity.
  task automatic send_packet(input int plen, input bit bad, input int full_pct);
    logic [W-1:0] hdr, x, par;
    logic [W-1:0] bytes[$];
    logic         exp_err;
    logic         last, ff;
    logic [W-1:0] b;
    string        tag;

    hdr = W'($urandom);
    x = hdr;
    bytes.delete();
    for (int i = 0; i < plen; i++) begin
      b = W'($urandom);
      bytes.push_back(b);
      x = x ^ b;
    end
    par = bad ? (x ^ W'($urandom_range(1, 255))) : x;
    exp_err = bad;
    bytes.push_back(par);

    exp_q.push_back(hdr);
    foreach (bytes[i]) exp_q.push_back(bytes[i]);

    drive(ST_DECODE_ADDRESS, 1'b1, 1'($urandom), hdr);
    step();
    check("rnd detect parity_done", 32'(bus.parity_done), 32'd0);
    check("rnd detect err", 32'(bus.err), 32'd0);

    drive(ST_LOAD_FIRST_DATA, 1'b1, 1'b0, W'($urandom));
    step();
    check("rnd header dout", 32'(bus.dout), 32'(exp_q.pop_front()));

    for (int k = 0; k < bytes.size(); k++) begin
      last = (k == bytes.size() - 1);
      ff = ($urandom_range(0, 99) < full_pct);
      tag = last ? "rnd parity dout" : "rnd payload dout";
      drive(ST_LOAD_DATA, !last, ff, bytes[k]);
      step();
      if (ff) begin
        repeat ($urandom_range(1, 2)) begin
          drive(ST_FIFO_FULL, !last, 1'b1, bytes[k]);
          step();
        end
        drive(ST_LOAD_AFTER_FULL, !last, 1'b0, bytes[k]);
        step();
      end
      check(tag, 32'(bus.dout), 32'(exp_q.pop_front()));
    end

    check("rnd parity_done set", 32'(bus.parity_done), 32'd1);
    check("rnd low_pkt_valid set", 32'(bus.low_pkt_valid), 32'd1);

    drive(ST_IDLE, 1'($urandom), 1'($urandom), W'($urandom));
    step();
    check("rnd err", 32'(bus.err), 32'(exp_err));

    drive(ST_RST_INT_REG, 1'($urandom), 1'($urandom), W'($urandom));
    step();
    check("rnd low_pkt_valid clear", 32'(bus.low_pkt_valid), 32'd0);
    check("rnd err hold", 32'(bus.err), 32'(exp_err));
    check("rnd parity_done hold", 32'(bus.parity_done), 32'd1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Directed vectors; each row is one clock, expectations after the edge.
    // Good packet 05,11,22 parity 36.
    add_row(0, ST_DECODE_ADDRESS,  1, 0, 8'h05, 8'h00, 0, 0, 0);
    add_row(0, ST_LOAD_FIRST_DATA, 1, 0, 8'h11, 8'h05, 0, 0, 0);
    add_row(0, ST_LOAD_DATA,       1, 0, 8'h11, 8'h11, 0, 0, 0);
    add_row(0, ST_LOAD_DATA,       1, 0, 8'h22, 8'h22, 0, 0, 0);
    add_row(0, ST_LOAD_DATA,       0, 0, 8'h36, 8'h36, 1, 1, 0);
    add_row(0, ST_IDLE,            0, 0, 8'h00, 8'h36, 1, 1, 0);
    add_row(0, ST_RST_INT_REG,     0, 0, 8'h00, 8'h36, 1, 0, 0);
    // Bad parity 37: err one cycle after parity_done, cleared by detect_add.
    add_row(0, ST_DECODE_ADDRESS,  1, 0, 8'h05, 8'h36, 0, 0, 0);
    add_row(0, ST_LOAD_FIRST_DATA, 1, 0, 8'h11, 8'h05, 0, 0, 0);
    add_row(0, ST_LOAD_DATA,       1, 0, 8'h11, 8'h11, 0, 0, 0);
    add_row(0, ST_LOAD_DATA,       1, 0, 8'h22, 8'h22, 0, 0, 0);
    add_row(0, ST_LOAD_DATA,       0, 0, 8'h37, 8'h37, 1, 1, 0);
    add_row(0, ST_IDLE,            0, 0, 8'h00, 8'h37, 1, 1, 1);
    add_row(0, ST_RST_INT_REG,     0, 0, 8'h00, 8'h37, 1, 0, 1);
    add_row(0, ST_DECODE_ADDRESS,  1, 0, 8'h05, 8'h37, 0, 0, 0);
    // Full while 22 is presented; 22 appears after laf_state.
    add_row(0, ST_LOAD_FIRST_DATA, 1, 0, 8'h11, 8'h05, 0, 0, 0);
    add_row(0, ST_LOAD_DATA,       1, 0, 8'h11, 8'h11, 0, 0, 0);
    add_row(0, ST_LOAD_DATA,       1, 1, 8'h22, 8'h11, 0, 0, 0);
    add_row(0, ST_FIFO_FULL,       1, 1, 8'h22, 8'h11, 0, 0, 0);
    add_row(0, ST_LOAD_AFTER_FULL, 1, 0, 8'h22, 8'h22, 0, 0, 0);
    add_row(0, ST_LOAD_DATA,       0, 0, 8'h36, 8'h36, 1, 1, 0);
    add_row(0, ST_IDLE,            0, 0, 8'h00, 8'h36, 1, 1, 0);
    add_row(0, ST_RST_INT_REG,     0, 0, 8'h00, 8'h36, 1, 0, 0);
    // Full on the parity byte; capture deferred to laf_state.
    add_row(0, ST_DECODE_ADDRESS,  1, 0, 8'h05, 8'h36, 0, 0, 0);
    add_row(0, ST_LOAD_FIRST_DATA, 1, 0, 8'h11, 8'h05, 0, 0, 0);
    add_row(0, ST_LOAD_DATA,       1, 0, 8'h11, 8'h11, 0, 0, 0);
    add_row(0, ST_LOAD_DATA,       1, 0, 8'h22, 8'h22, 0, 0, 0);
    add_row(0, ST_LOAD_DATA,       0, 1, 8'h36, 8'h22, 0, 1, 0);
    add_row(0, ST_FIFO_FULL,       0, 1, 8'h36, 8'h22, 0, 1, 0);
    add_row(0, ST_LOAD_AFTER_FULL, 0, 0, 8'h36, 8'h36, 1, 1, 0);
    add_row(0, ST_IDLE,            0, 0, 8'h00, 8'h36, 1, 1, 0);
    add_row(0, ST_RST_INT_REG,     0, 0, 8'h00, 8'h36, 1, 0, 0);
    // Reset mid-payload, then packet 02,A0 parity A2.
    add_row(0, ST_DECODE_ADDRESS,  1, 0, 8'h05, 8'h36, 0, 0, 0);
    add_row(0, ST_LOAD_FIRST_DATA, 1, 0, 8'h11, 8'h05, 0, 0, 0);
    add_row(0, ST_LOAD_DATA,       1, 0, 8'h11, 8'h11, 0, 0, 0);
    add_row(1, ST_LOAD_DATA,       0, 1, 8'h22, 8'h00, 0, 0, 0);
    add_row(0, ST_DECODE_ADDRESS,  1, 0, 8'h02, 8'h00, 0, 0, 0);
    add_row(0, ST_LOAD_FIRST_DATA, 1, 0, 8'hA0, 8'h02, 0, 0, 0);
    add_row(0, ST_LOAD_DATA,       1, 0, 8'hA0, 8'hA0, 0, 0, 0);
    add_row(0, ST_LOAD_DATA,       0, 0, 8'hA2, 8'hA2, 1, 1, 0);
    add_row(0, ST_IDLE,            0, 0, 8'h00, 8'hA2, 1, 1, 0);
    add_row(0, ST_RST_INT_REG,     0, 0, 8'h00, 8'hA2, 1, 0, 0);

    // Reset held for two cycles with random inputs.
    resetr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(router_state_e'($urandom_range(0, 6)), 1'($urandom), 1'($urandom), W'($urandom));
      step();
      check_outs($sformatf("reset%0d", i), '0, 1'b0, 1'b0, 1'b0);
    end
    resetr = 1'b0;

    foreach (tbl[i]) begin
      resetr = tbl[i].rst;
      drive(tbl[i].st, tbl[i].pv, tbl[i].ff, tbl[i].din);
      step();
      check_outs($sformatf("row%0d", i), tbl[i].e_dout, tbl[i].e_pd, tbl[i].e_lpv, tbl[i].e_err);
    end
    resetr = 1'b0;

    // Randomized packets against the packet-level model.
    for (int p = 0; p < 60; p++) begin
      send_packet($urandom_range(1, 6), ($urandom_range(0, 99) < 35), 30);
    end

    check("exp_q drained", 32'(exp_q.size()), 32'd0);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
